mul_seq_ctrl: RTL and testbench



---
 rtl/mul_seq_pkg.sv | 16 +
 rtl/mul_seq_add.sv | 24 ++
 rtl/mul_seq_ctrl.sv | 107 ++++++++++
 tb/tb_mul_seq_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mul_seq_pkg.sv
// Shared types and widths for the sequential shift-and-add multiplier.
// Build option: MUL_SEQ_ZERO_SKIP_EN.
package mul_seq_pkg;

  localparam int A_W   = 4;
  localparam int B_W   = 3;
  localparam int RES_W = A_W + B_W;
  localparam int CNT_W = $clog2(B_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_seq_add.sv
// W-bit ripple-carry adder, carry-in fixed at 0.
// Port-compatible with the team's 4-bit adder.
module mul_seq_add #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] s,
  output logic         co
);

  logic w_c;

  always_comb begin
    s   = '0;
    w_c = 1'b0;
    for (int i = 0; i < W; i++) begin
      s[i] = a[i] ^ b[i] ^ w_c;
      w_c  = (a[i] & b[i]) | (w_c & (a[i] ^ b[i]));
    end
    co = w_c;
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential A_W x B_W unsigned multiplier, one add per cycle.
// Build option: MUL_SEQ_ZERO_SKIP_EN (zero operands finish at once).
module mul_seq_ctrl
  import mul_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  output logic             busy,
  output logic             done,
  output logic [RES_W-1:0] res
);

  state_t           r_state;
  state_t           w_next;
  logic [A_W-1:0]   r_a;
  logic [RES_W:0]   r_p;
  logic [CNT_W-1:0] r_cnt;
  logic [RES_W-1:0] r_res;

  logic             w_accept;
  logic             w_skip;
  logic             w_last;
  logic [A_W-1:0]   w_acc;
  logic [A_W-1:0]   w_addend;
  logic [A_W-1:0]   w_sum;
  logic             w_co;
  logic [RES_W:0]   w_p_nxt;

  assign w_accept = start &&
                    (r_state == IDLE ||
                     r_state == DONE);

`ifdef MUL_SEQ_ZERO_SKIP_EN
  assign w_skip = (a == '0) || (b == '0);
`else
  assign w_skip = 1'b0;
`endif

  assign w_last   = (r_cnt == CNT_W'(B_W - 1));
  assign w_acc    = r_p[RES_W-1:B_W];
  assign w_addend = r_p[0] ? r_a : '0;

  mul_seq_add #(
    .W (A_W)
  ) u_add (
    .a  (w_acc),
    .b  (w_addend),
    .s  (w_sum),
    .co (w_co)
  );

  // Logical right shift of {carry, sum, low multiplier bits}
  assign w_p_nxt = {1'b0, w_co, w_sum, r_p[B_W-1:1]};

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept)
          w_next = w_skip ? DONE : CALC;
      end
      CALC: begin
        if (w_last)
          w_next = DONE;
      end
      DONE: begin
        if (w_accept)
          w_next = w_skip ? DONE : CALC;
        else
          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_p     <= '0;
      r_cnt   <= '0;
      r_res   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a   <= a;
        r_p   <= {{(A_W + 1){1'b0}}, b};
        r_cnt <= '0;
        if (w_skip)
          r_res <= '0;
      end else if (r_state == CALC) begin
        r_p   <= w_p_nxt;
        r_cnt <= r_cnt + 1'b1;
        if (w_last)
          r_res <= w_p_nxt[RES_W-1:0];
      end
    end
  end

  assign busy = (r_state == CALC);
  assign done = (r_state == DONE);
  assign res  = r_res;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl.
// Honours MUL_SEQ_ZERO_SKIP_EN when computing expectations.
module tb_mul_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a;
  logic [2:0] b;
  logic       busy;
  logic       done;
  logic [6:0] res;

  int checks;
  int failures;

`ifdef MUL_SEQ_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  mul_seq_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .res   (res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  // One start pulse, then watch a bounded window.
  task automatic op(input logic [3:0] ta,
                    input logic [2:0] tb_,
                    input string tag);
    int ndone;
    int first;
    int sawbusy;
    int exp_lat;
    int exp_busy;
    logic [6:0] got;
    ndone   = 0;
    first   = 0;
    sawbusy = 0;
    got     = 'x;
    start = 1'b1;
    a     = ta;
    b     = tb_;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (done) begin
        ndone++;
        if (first == 0) first = k;
        got = res;
      end
      if (busy) sawbusy = 1;
      tick();
    end
    exp_busy = (SKIP && (ta == 0 || tb_ == 0)) ? 0 : 1;
    exp_lat  = exp_busy ? 4 : 1;
    chk({tag, "_res"}, 32'(got), 32'(ta) * 32'(tb_));
    chk({tag, "_ndone"}, ndone, 1);
    chk({tag, "_lat"}, first, exp_lat);
    chk({tag, "_busy"}, sawbusy, exp_busy);
  endtask

  initial begin
    int nd;
    checks   = 0;
    failures = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_res", 32'(res), 0);
    rst_n = 1'b1;
    tick();

    // 15 x 7 with cycle-by-cycle timing
    start = 1'b1;
    a = 4'd15;
    b = 3'd7;
    tick();
    start = 1'b0;
    chk("t1_busy1", 32'(busy), 1);
    chk("t1_done1", 32'(done), 0);
    tick();
    chk("t1_busy2", 32'(busy), 1);
    tick();
    chk("t1_busy3", 32'(busy), 1);
    tick();
    chk("t1_done", 32'(done), 1);
    chk("t1_nobusy", 32'(busy), 0);
    chk("t1_res", 32'(res), 105);
    tick();
    chk("t1_done_low", 32'(done), 0);
    chk("t1_hold", 32'(res), 105);

    // exhaustive sweep
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 8; j++)
        op(4'(i), 3'(j), "sweep");

    // back-to-back with start held
    start = 1'b1;
    a = 4'd9;
    b = 3'd4;
    tick();
    a = 4'd3;
    b = 3'd5;
    tick();
    tick();
    tick();
    chk("b2b_done1", 32'(done), 1);
    chk("b2b_res1", 32'(res), 36);
    tick();
    start = 1'b0;
    chk("b2b_recalc", 32'(busy), 1);
    chk("b2b_hold", 32'(res), 36);
    tick();
    tick();
    tick();
    chk("b2b_done2", 32'(done), 1);
    chk("b2b_res2", 32'(res), 15);
    tick();

    // starts during CALC are ignored
    start = 1'b1;
    a = 4'd6;
    b = 3'd6;
    tick();
    a = 4'd1;
    b = 3'd1;
    tick();
    tick();
    start = 1'b0;
    tick();
    chk("ign_done", 32'(done), 1);
    chk("ign_res", 32'(res), 36);
    nd = 0;
    tick();
    for (int k = 0; k < 6; k++) begin
      if (done) nd++;
      tick();
    end
    chk("ign_extra", nd, 0);

    // reset on the second CALC edge
    start = 1'b1;
    a = 4'd12;
    b = 3'd5;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_done", 32'(done), 0);
    chk("mrst_res", 32'(res), 0);
    rst_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 6; k++) begin
      if (done) nd++;
      tick();
    end
    chk("mrst_nodone", nd, 0);

    // zero operand
    op(4'd0, 3'd5, "zero");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
